// File: rtl/sdr_host_arbiter.sv
// sdr_host_arbiter: round-robin sharing of one SDR SDRAM controller host port among NREQ requesters.
// Define SDR_ARB_P0_PRIORITY_EN to give port 0 absolute priority over the round robin.
module sdr_host_arbiter #(
    parameter int NREQ   = 4,
    parameter int ASIZE  = 23,
    parameter int DSIZE  = 32,
    parameter int BURST  = 4,
    parameter int WR_LAT = 0,
    parameter int RD_LAT = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ-1:0]           RNW,
    input  logic [NREQ*ASIZE-1:0]     REQ_ADDR,
    input  logic [NREQ*DSIZE-1:0]     REQ_WDATA,
    input  logic [NREQ*DSIZE/8-1:0]   REQ_DM,
    output logic [NREQ-1:0]           GNT,
    output logic [NREQ-1:0]           WR_STB,
    output logic [NREQ-1:0]           RD_VLD,
    output logic [DSIZE-1:0]          RD_DATA,
    output logic                      BUSY,
    output logic [2:0]                CMD,
    output logic [ASIZE-1:0]          ADDR,
    input  logic                      CMDACK,
    output logic [DSIZE-1:0]          DATAIN,
    output logic [DSIZE/8-1:0]        DM,
    input  logic [DSIZE-1:0]          DATAOUT
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MW = DSIZE / 8;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WLAT, S_WDATA, S_RWAIT, S_RDATA} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, sel, jx;
    logic rnw_q, rnw_d;
    logic [2:0] cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DSIZE-1:0] datain_q, datain_d, rd_data_q, rd_data_d;
    logic [MW-1:0] dm_q, dm_d;
    logic [NREQ-1:0] wr_stb_q, wr_stb_d, rd_vld_q, rd_vld_d, win_oh;
    int j;
    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
    // Scan downwards so the nearest requester after the pointer is the last one written.
    always_comb begin
        sel = ptr_q;
        j = 0;
        jx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            jx = IW'(j);
            if (REQ[jx]) sel = jx;
        end
`ifdef SDR_ARB_P0_PRIORITY_EN
        if (REQ[0]) sel = '0;
`endif
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        win_d = win_q;
        rnw_d = rnw_q;
        cmd_d = cmd_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: if (|REQ) begin
                state_d = S_CMD;
                win_d = sel;
                rnw_d = RNW[sel];
                cmd_d = RNW[sel] ? 3'b001 : 3'b010;
                addr_d = REQ_ADDR[sel*ASIZE +: ASIZE];
`ifdef SDR_ARB_P0_PRIORITY_EN
                ptr_d = (sel == '0) ? ptr_q : sel;
`else
                ptr_d = sel;
`endif
            end
            S_CMD: if (CMDACK) begin
                cmd_d = 3'b000;
                cnt_d = '0;
                state_d = rnw_q ? ((RD_LAT > 1) ? S_RWAIT : S_RDATA) : ((WR_LAT > 0) ? S_WLAT : S_WDATA);
            end
            S_WLAT: begin
                cnt_d = (cnt_q == 4'(WR_LAT - 1)) ? 4'd0 : cnt_q + 4'd1;
                state_d = (cnt_q == 4'(WR_LAT - 1)) ? S_WDATA : S_WLAT;
            end
            S_RWAIT: begin
                cnt_d = (cnt_q == 4'(RD_LAT - 2)) ? 4'd0 : cnt_q + 4'd1;
                state_d = (cnt_q == 4'(RD_LAT - 2)) ? S_RDATA : S_RWAIT;
            end
            S_WDATA, S_RDATA: begin
                cnt_d = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(BURST - 1)) ? S_IDLE : state_q;
            end
            default: state_d = S_IDLE;
        endcase
        // Write beats are captured one cycle ahead so they sit on DATAIN during WDATA itself.
        datain_d = (state_d == S_WDATA) ? REQ_WDATA[win_q*DSIZE +: DSIZE] : '0;
        dm_d = (state_d == S_WDATA) ? REQ_DM[win_q*MW +: MW] : '0;
        wr_stb_d = (state_d == S_WDATA) ? win_oh : '0;
        rd_vld_d = (state_q == S_RDATA) ? win_oh : '0;
        rd_data_d = (state_q == S_RDATA) ? DATAOUT : rd_data_q;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q <= IW'(NREQ - 1);
            win_q <= '0;
            rnw_q <= 1'b0;
            cmd_q <= 3'b000;
            addr_q <= '0;
            cnt_q <= '0;
            datain_q <= '0;
            dm_q <= '0;
            wr_stb_q <= '0;
            rd_vld_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            win_q <= win_d;
            rnw_q <= rnw_d;
            cmd_q <= cmd_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            datain_q <= datain_d;
            dm_q <= dm_d;
            wr_stb_q <= wr_stb_d;
            rd_vld_q <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end
    assign GNT = (state_q == S_CMD && CMDACK) ? win_oh : '0;
    assign WR_STB = wr_stb_q;
    assign RD_VLD = rd_vld_q;
    assign RD_DATA = rd_data_q;
    assign BUSY = (state_q != S_IDLE);
    assign CMD = cmd_q;
    assign ADDR = addr_q;
    assign DATAIN = datain_q;
    assign DM = dm_q;
endmodule

// File: tb/tb_sdr_host_arbiter.sv
// tb_sdr_host_arbiter: table of transactions against a small controller/client model, plus reset corners.
module tb_sdr_host_arbiter;
    localparam int NREQ = 4, ASIZE = 23, DSIZE = 32, BURST = 4, RD_LAT = 5;
`ifdef SDR_ARB_P0_PRIORITY_EN
    localparam bit PRI = 1'b1;
`else
    localparam bit PRI = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [3:0] req = '0;
    logic [3:0] rnw = 4'b1010;
    logic [NREQ*ASIZE-1:0] req_addr;
    logic [NREQ*DSIZE-1:0] req_wdata;
    logic [NREQ*4-1:0] req_dm;
    logic [3:0] gnt, wr_stb, rd_vld;
    logic [31:0] rd_data, datain;
    logic busy;
    logic [2:0] cmd;
    logic [22:0] addr;
    logic cmdack = 1'b0;
    logic [3:0] dm;
    logic [31:0] dataout = '0;
    logic [22:0] addrs [4] = '{23'h000040, 23'h000080, 23'h000100, 23'h000200};
    int stb_cnt [4] = '{default: 0};
    int npass = 0, ntot = 0;

    sdr_host_arbiter #(.NREQ(NREQ), .ASIZE(ASIZE), .DSIZE(DSIZE), .BURST(BURST), .WR_LAT(0), .RD_LAT(RD_LAT)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .RNW(rnw), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .REQ_DM(req_dm), .GNT(gnt), .WR_STB(wr_stb), .RD_VLD(rd_vld), .RD_DATA(rd_data), .BUSY(busy),
        .CMD(cmd), .ADDR(addr), .CMDACK(cmdack), .DATAIN(datain), .DM(dm), .DATAOUT(dataout)
    );

    assign req_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};
    // Client: beat 0 is offered at grant, then each strobe moves it to the next beat.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            req_wdata[p*32 +: 32] = {8'(208 + p), 16'h0, 8'(gnt[p] ? 0 : stb_cnt[p] + int'(wr_stb[p]))};
            req_dm[p*4 +: 4] = 4'(p + 1);
        end
    end
    always @(posedge clk)
        for (int p = 0; p < 4; p++)
            if (gnt[p]) stb_cnt[p] <= 0;
            else if (wr_stb[p]) stb_cnt[p] <= stb_cnt[p] + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic rst_chk();
        chk("rst_ctl", {gnt, wr_stb, rd_vld, busy, cmd, dm}, 64'd0);
        chk("rst_datain", datain, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_addr", addr, 64'd0);
    endtask

    task automatic txn(input logic [3:0] r, input int dly, input int w, input bit drop, input int rb, input bit hold);
        logic [3:0] oh;
        oh = 4'(1 << w);
        req = r;
        for (int k = 0; k < 20 && cmd == 3'b000; k++) begin
            @(negedge clk);
            #1;
        end
        chk("cmd_code", cmd, rnw[w] ? 64'd1 : 64'd2);
        chk("cmd_addr", addr, addrs[w]);
        if (cmd == 3'b000) return;
        if (drop) req[w] = 1'b0;
        for (int d = 0; d < dly; d++) begin
            chk("gnt_early", gnt, 64'd0);
            @(negedge clk);
            #1;
        end
        cmdack = 1'b1;
        #1;
        chk("gnt", gnt, oh);
        chk("addr_at_ack", addr, addrs[w]);
        @(negedge clk);
        cmdack = 1'b0;
        if (!hold) req = '0;
        #1;
        chk("cmd_nop", cmd, 64'd0);
        if (!rnw[w]) begin
            for (int k = 0; k < BURST; k++) begin
                if (k == rb) begin
                    rst = 1'b1;
                    #1;
                    rst_chk();
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    return;
                end
                chk("wr_stb", wr_stb, oh);
                chk("datain", datain, {8'(208 + w), 16'h0, 8'(k)});
                chk("dm", dm, 4'(w + 1));
                @(negedge clk);
                #1;
            end
            chk("wr_stb_end", wr_stb, 64'd0);
            chk("datain_end", datain, 64'd0);
            chk("busy_end", busy, 64'd0);
        end else begin
            for (int c = 1; c <= RD_LAT + BURST; c++) begin
                dataout = (c >= RD_LAT && c < RD_LAT + BURST) ? 32'hA0 + 32'(c - RD_LAT) : 32'hDEADBEEF;
                #1;
                if (c > RD_LAT) begin
                    chk("rd_vld", rd_vld, oh);
                    chk("rd_data", rd_data, 32'hA0 + 32'(c - RD_LAT - 1));
                end else chk("rd_vld_idle", rd_vld, 64'd0);
                @(negedge clk);
            end
            #1;
            chk("rd_vld_end", rd_vld, 64'd0);
        end
    endtask

    typedef struct {
        bit rst;
        logic [3:0] req;
        int dly;
        int win;
        bit drop;
        int rb;
    } vec_t;
    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b0, 4'b0100, 3, 2, 1'b0, -1};
        tbl[1]  = '{1'b0, 4'b0010, 1, 1, 1'b0, -1};
        tbl[2]  = '{1'b0, 4'b1000, 2, 3, 1'b1, -1};
        tbl[3]  = '{1'b1, 4'b1111, 0, 0, 1'b0, -1};
        tbl[4]  = '{1'b0, 4'b1111, 0, PRI ? 0 : 1, 1'b0, -1};
        tbl[5]  = '{1'b0, 4'b1111, 1, PRI ? 0 : 2, 1'b0, -1};
        tbl[6]  = '{1'b0, 4'b1111, 0, PRI ? 0 : 3, 1'b0, -1};
        tbl[7]  = '{1'b0, 4'b1111, 2, 0, 1'b0, -1};
        tbl[8]  = '{1'b0, 4'b0100, 0, 2, 1'b0, 1};
        tbl[9]  = '{1'b0, 4'b1111, 0, 0, 1'b0, -1};
        tbl[10] = '{1'b0, 4'b1111, 1, PRI ? 0 : 1, 1'b0, -1};
        #3;
        rst_chk();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_busy", busy, 64'd0);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
            end
            txn(tbl[i].req, tbl[i].dly, tbl[i].win, tbl[i].drop, tbl[i].rb,
                (i + 1 < 11) && (tbl[i+1].req == tbl[i].req) && !tbl[i+1].rst);
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end
endmodule
